mux_arbiter: RTL
================

Name: mux_arbiter

Overview:
- Two-requester arbiter and sequencer for the team's 2:1 NOR-gate multiplexer datapath.
- Decides which source owns the shared output channel and drives the mux select line (select=0 passes a, select=1 passes b, matching the mux convention).
- Round-robin with a bounded hold time, so one requester cannot starve the other.
- Sits between two producer blocks and one consumer that samples data_out when valid_out=1.

Parameters:
WIDTH, 1, bit width of data_a, data_b, data_out
MAX_HOLD, 4, max consecutive cycles an owner keeps the grant while the other side is requesting (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous reset, active-high
req_a  input  1  requester A wants the channel
req_b  input  1  requester B wants the channel
data_a  input  WIDTH  data from requester A
data_b  input  WIDTH  data from requester B
gnt_a  output  1  A owns the channel (registered)
gnt_b  output  1  B owns the channel (registered)
sel  output  1  mux select, 0=a, 1=b (registered)
valid_out  output  1  gnt_a | gnt_b
data_out  output  WIDTH  sel ? data_b : data_a when valid_out=1, else all zeros (combinational from registered sel)

Behaviour:
- Reset values (reset=1 at a rising edge):
  - state=IDLE; gnt_a=0, gnt_b=0, sel=0, valid_out=0, data_out=0.
  - hold_cnt=0; last_served=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B). gnt_a and gnt_b are never both 1.
- Latency: a request sampled at edge N yields a grant visible after edge N (one cycle). data_out follows data inputs combinationally while granted.
- IDLE:
  - req_a only -> OWN_A, sel=0.
  - req_b only -> OWN_B, sel=1.
  - Both requesting -> the side not equal to last_served.
  - Neither requesting -> stay in IDLE; sel holds its last value.
- OWN_X (other side = Y), evaluated every edge:
  - req_X=0 and req_Y=1 -> OWN_Y directly, with no IDLE bubble.
  - req_X=0 and req_Y=0 -> IDLE.
  - req_X=1, req_Y=1, hold_cnt==MAX_HOLD-1 -> preempt to OWN_Y.
  - req_X=1, otherwise -> stay; hold_cnt increments only while req_Y=1 and saturates at MAX_HOLD-1; with req_Y=0 the owner keeps the grant indefinitely.
- On every entry to OWN_X: hold_cnt=0, last_served=X, sel updated the same edge.
- hold_cnt is 4 bits wide; it never wraps.
- MAX_HOLD=1: with both requesting, ownership alternates every cycle.
- Reset mid-ownership: next edge forces reset values, and any pending grant is discarded. After reset is released, arbitration restarts with A preferred.
- Requests changing while in IDLE are only sampled at the edge. There are no combinational paths from req_* to gnt_*.

Optional Feature:
MUX_ARB_STATS_EN
- Defined:
  - Adds two outputs, grant_cnt_a[7:0] and grant_cnt_b[7:0].
  - Each counts entries into OWN_A and OWN_B respectively; an entry is a grant transition, not a cycle held.
  - Counters saturate at 255 and clear to 0 on reset.
- Undefined: ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
1. Reset held 2 cycles with req_a=req_b=1 -> gnt_a=0, gnt_b=0, sel=0, valid_out=0, data_out=0 throughout reset.
2. After reset, req_a=1, req_b=0, data_a=1, data_b=0 -> gnt_a=1, sel=0, data_out=1 from edge 1; still granted after 20 cycles (no preemption without competition).
3. MAX_HOLD=4, req_a=req_b=1 from reset release -> A granted cycles 1-4, B granted cycles 5-8, A again 9-12; sel toggles 0/1 accordingly; gnt_a&gnt_b never 1.
4. A owns, req_b=1, then req_a drops at edge k -> gnt_b=1, sel=1 at edge k+1; valid_out stays 1 with no gap; data_out switches from data_a to data_b.
5. B owns with both requesting; assert reset one cycle mid-hold -> all outputs return to reset values the next edge; after release with both requesting, A is granted first.
6. With MUX_ARB_STATS_EN defined, run scenario 3 for 12 cycles -> grant_cnt_a=2, grant_cnt_b=1; force 300 A-entries -> grant_cnt_a saturates at 255.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with bounded hold, driving a 2:1 mux select.
// Optional grant-entry counters are enabled by defining MUX_ARB_STATS_EN.
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             valid_out,
`ifdef MUX_ARB_STATS_EN
    output logic [7:0]       grant_cnt_a,
    output logic [7:0]       grant_cnt_b,
`endif
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [3:0] hold_cnt_nxt;
    logic       last_b;
    logic       last_b_nxt;
    logic       sel_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            last_b   <= 1'b1;
            sel      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last_b   <= last_b_nxt;
            sel      <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_b_nxt   = last_b;
        sel_nxt      = sel;

        unique case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = last_b ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_nxt = OWN_A;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_nxt = req_b ? OWN_B : IDLE;
                end else if (req_b && hold_cnt == HOLD_LAST) begin
                    state_nxt = OWN_B;
                end else if (req_b) begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_nxt = req_a ? OWN_A : IDLE;
                end else if (req_a && hold_cnt == HOLD_LAST) begin
                    state_nxt = OWN_A;
                end else if (req_a) begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Any change of owner restarts the hold window and records who was served.
        if (state_nxt != state && state_nxt == OWN_A) begin
            hold_cnt_nxt = 4'd0;
            last_b_nxt   = 1'b0;
            sel_nxt      = 1'b0;
        end else if (state_nxt != state && state_nxt == OWN_B) begin
            hold_cnt_nxt = 4'd0;
            last_b_nxt   = 1'b1;
            sel_nxt      = 1'b1;
        end
    end

    assign gnt_a     = (state == OWN_A);
    assign gnt_b     = (state == OWN_B);
    assign valid_out = gnt_a | gnt_b;
    assign data_out  = valid_out ? (sel ? data_b : data_a) : '0;

`ifdef MUX_ARB_STATS_EN
    logic enter_a;
    logic enter_b;

    assign enter_a = (state != OWN_A) && (state_nxt == OWN_A);
    assign enter_b = (state != OWN_B) && (state_nxt == OWN_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_a <= 8'd0;
            grant_cnt_b <= 8'd0;
        end else begin
            if (enter_a && grant_cnt_a != 8'hFF) begin
                grant_cnt_a <= grant_cnt_a + 8'd1;
            end
            if (enter_b && grant_cnt_b != 8'hFF) begin
                grant_cnt_b <= grant_cnt_b + 8'd1;
            end
        end
    end
`endif

endmodule
